// File: rtl/riscv_realign_pkg.sv
// Shared types and helpers for the fetch realigner: FSM states, buffer depth, RVC detection.
package riscv_realign_pkg;

    typedef enum logic {
        RUN       = 1'b0,
        SKIP_HALF = 1'b1
    } state_t;

    localparam int HB_DEPTH = 3;

    function automatic logic is_compressed(input logic [15:0] halfword);
        return halfword[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/riscv_realign_hwbuf.sv
// Three-entry halfword FIFO: pops apply before pushes within a cycle; clear drops all entries.
// Zero-cycle read of head entries from registers; the caller guarantees no overflow.
module riscv_realign_hwbuf
    import riscv_realign_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        push1,
    input  logic        push2,
    input  logic [15:0] push_lo,
    input  logic [15:0] push_hi,
    input  logic        pop1,
    input  logic        pop2,
    output logic [15:0] head0,
    output logic [15:0] head1,
    output logic [1:0]  count
);

    logic [15:0] hb     [HB_DEPTH];
    logic [15:0] hb_nxt [HB_DEPTH];
    logic [1:0]  cnt_pop;
    logic [1:0]  cnt_nxt;

    always_comb begin
        hb_nxt  = hb;
        cnt_pop = count;
        if (pop2) begin
            hb_nxt[0] = hb[2];
            cnt_pop   = count - 2'd2;
        end else if (pop1) begin
            hb_nxt[0] = hb[1];
            hb_nxt[1] = hb[2];
            cnt_pop   = count - 2'd1;
        end
        // Pushed halfwords land right behind whatever survives the pop.
        for (int i = 0; i < HB_DEPTH; i++) begin
            if ((push1 || push2) && 2'(i) == cnt_pop)
                hb_nxt[i] = push_lo;
            else if (push2 && 2'(i) == cnt_pop + 2'd1)
                hb_nxt[i] = push_hi;
        end
        cnt_nxt = cnt_pop + (push2 ? 2'd2 : (push1 ? 2'd1 : 2'd0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 2'd0;
            for (int i = 0; i < HB_DEPTH; i++) hb[i] <= 16'h0;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            count <= cnt_nxt;
            hb    <= hb_nxt;
        end
    end

    assign head0 = hb[0];
    assign head1 = hb[1];

endmodule

// File: rtl/riscv_fetch_realigner.sv
// Realigns word fetches into RVC/32-bit instructions; one cycle latency, or zero with RISCV_REALIGN_BYPASS_EN.
// Fetch stalls once two or more halfwords are buffered; outputs hold while the decoder stalls.
module riscv_fetch_realigner
    import riscv_realign_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_riscv_realign_clk,
    input  logic            i_riscv_realign_rst_n,
    output logic [XLEN-1:0] o_riscv_realign_fetch_addr,
    input  logic [31:0]     i_riscv_realign_fetch_word,
    input  logic            i_riscv_realign_fetch_valid,
    output logic            o_riscv_realign_fetch_ready,
    input  logic            i_riscv_realign_flush,
    input  logic [XLEN-1:0] i_riscv_realign_flush_pc,
    output logic [31:0]     o_riscv_realign_inst,
    output logic [XLEN-1:0] o_riscv_realign_pc,
    output logic            o_riscv_realign_compressed,
    output logic            o_riscv_realign_valid,
    input  logic            i_riscv_realign_ready
);

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [31:0]     word;
    state_t          state;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] fetch_addr;
    logic [15:0]     hb0;
    logic [15:0]     hb1;
    logic [1:0]      count;
    logic            buf_cmp;
    logic            buf_valid;
    logic            fetch_ready;
    logic            accept;
    logic            byp;
    logic            out_valid;
    logic            out_cmp;
    logic [31:0]     out_inst;
    logic            consume;
    logic            push1;
    logic            push2;
    logic [15:0]     push_lo;
    logic [15:0]     push_hi;
    logic            pop1;
    logic            pop2;
    logic            flush_pc_bit0_unused;

    assign clk                  = i_riscv_realign_clk;
    assign rst_n                = i_riscv_realign_rst_n;
    assign flush                = i_riscv_realign_flush;
    assign word                 = i_riscv_realign_fetch_word;
    assign flush_pc_bit0_unused = i_riscv_realign_flush_pc[0];

    always_comb begin
        buf_cmp     = (count >= 2'd1) && is_compressed(hb0);
        buf_valid   = buf_cmp || (count >= 2'd2);
        fetch_ready = rst_n && (count <= 2'd1) && !flush;
        accept      = i_riscv_realign_fetch_valid && fetch_ready;
        byp         = 1'b0;
        out_valid   = rst_n && !flush && buf_valid;
        out_cmp     = buf_cmp;
        out_inst    = buf_cmp ? {16'h0, hb0} : {hb1, hb0};
        push1       = 1'b0;
        push2       = 1'b0;
        push_lo     = word[15:0];
        push_hi     = word[31:16];
        if (accept) begin
            if (state == SKIP_HALF) begin
                push1   = 1'b1;
                push_lo = word[31:16];
            end else begin
                push2 = 1'b1;
            end
        end
`ifdef RISCV_REALIGN_BYPASS_EN
        byp = accept && (count == 2'd0) && (state == RUN);
        if (byp) begin
            out_valid = 1'b1;
            out_cmp   = is_compressed(word[15:0]);
            out_inst  = out_cmp ? {16'h0, word[15:0]} : word;
        end
`endif
        consume = out_valid && i_riscv_realign_ready;
        pop1    = consume && !byp && out_cmp;
        pop2    = consume && !byp && !out_cmp;
        // A consumed bypass instruction only leaves its spare upper halfword behind.
        if (byp && consume) begin
            push2   = 1'b0;
            push1   = out_cmp;
            push_lo = word[31:16];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            head_pc    <= RESET_PC;
            fetch_addr <= RESET_PC;
        end else if (flush) begin
            head_pc    <= {i_riscv_realign_flush_pc[XLEN-1:1], 1'b0};
            fetch_addr <= {i_riscv_realign_flush_pc[XLEN-1:2], 2'b00};
            state      <= i_riscv_realign_flush_pc[1] ? SKIP_HALF : RUN;
        end else begin
            if (accept) begin
                fetch_addr <= fetch_addr + XLEN'(4);
                state      <= RUN;
            end
            if (consume)
                head_pc <= head_pc + (out_cmp ? XLEN'(2) : XLEN'(4));
        end
    end

    riscv_realign_hwbuf u_hwbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .push1   (push1),
        .push2   (push2),
        .push_lo (push_lo),
        .push_hi (push_hi),
        .pop1    (pop1),
        .pop2    (pop2),
        .head0   (hb0),
        .head1   (hb1),
        .count   (count)
    );

    assign o_riscv_realign_fetch_addr  = fetch_addr;
    assign o_riscv_realign_fetch_ready = fetch_ready;
    assign o_riscv_realign_valid       = out_valid;
    assign o_riscv_realign_compressed  = rst_n && out_cmp;
    assign o_riscv_realign_inst        = rst_n ? out_inst : 32'h0;
    assign o_riscv_realign_pc          = head_pc;

endmodule

// File: tb/tb_riscv_fetch_realigner.sv
// Directed and randomized bench; expected instructions come from a halfword view of the memory image.
module tb_riscv_fetch_realigner;

    logic        clk;
    logic        rst_n;
    logic [63:0] fetch_addr;
    logic [31:0] fetch_word;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        flush;
    logic [63:0] flush_pc;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        compressed;
    logic        valid;
    logic        ready;

    logic [31:0] mem [128];
    int          errors = 0;
    int          checks = 0;

    assign fetch_word = mem[fetch_addr[8:2]];

    riscv_fetch_realigner #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .i_riscv_realign_clk         (clk),
        .i_riscv_realign_rst_n       (rst_n),
        .o_riscv_realign_fetch_addr  (fetch_addr),
        .i_riscv_realign_fetch_word  (fetch_word),
        .i_riscv_realign_fetch_valid (fetch_valid),
        .o_riscv_realign_fetch_ready (fetch_ready),
        .i_riscv_realign_flush       (flush),
        .i_riscv_realign_flush_pc    (flush_pc),
        .o_riscv_realign_inst        (inst),
        .o_riscv_realign_pc          (pc),
        .o_riscv_realign_compressed  (compressed),
        .o_riscv_realign_valid       (valid),
        .i_riscv_realign_ready       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and settle before sampling.
    task automatic cyc(input logic fv, input logic rdy, input logic fl, input logic [63:0] fpc);
        @(negedge clk);
        fetch_valid = fv;
        ready       = rdy;
        flush       = fl;
        flush_pc    = fpc;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fetch_valid = 1'b0; ready = 1'b0; flush = 1'b0; flush_pc = '0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] hw_at(input logic [63:0] a);
        logic [31:0] w;
        w = mem[a[8:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    initial begin
        logic [63:0] exp_pc;
        logic [15:0] h;
        logic        fv, rdy, fl, prev_fl;
        logic [63:0] fpc;
        int          consumes;

        rst_n = 1'b0;
        fetch_valid = 1'b0; ready = 1'b0; flush = 1'b0; flush_pc = '0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0] = 32'h0013_0001;
        mem[1] = 32'h00A0_0093;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_valid", valid, 1'b0);
        chk("rst_comp", compressed, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_fready", fetch_ready, 1'b0);
        chk("rst_faddr", fetch_addr, 64'h0);
        rst_n = 1'b1;

        // Compressed followed by a straddling 32-bit instruction.
        cyc(1, 1, 0, 0);
        chk("t1_faddr0", fetch_addr, 64'h0);
        chk("t1_valid0", valid, 1'b0);
        cyc(1, 1, 0, 0);
        chk("t1_inst_cnop", inst, 32'h0000_0001);
        chk("t1_comp_cnop", compressed, 1'b1);
        chk("t1_pc_cnop", pc, 64'h0);
        chk("t1_fready_cnt2", fetch_ready, 1'b0);
        chk("t1_faddr4", fetch_addr, 64'h4);
        cyc(1, 1, 0, 0);
        chk("t1_wait_upper", valid, 1'b0);
        chk("t1_fready_cnt1", fetch_ready, 1'b1);
        cyc(1, 1, 0, 0);
        chk("t1_valid_full", valid, 1'b1);
        chk("t1_inst_full", inst, 32'h0093_0013);
        chk("t1_comp_full", compressed, 1'b0);
        chk("t1_pc_full", pc, 64'h2);
        chk("t1_faddr8", fetch_addr, 64'h8);

        // Straddle held by decoder backpressure, then flush over a pending instruction.
        do_reset();
        mem[1] = 32'h1234_0093;
        mem[2] = 32'h0001_0001;
        mem[64] = 32'h4505_0001;
        mem[65] = 32'h0001_0001;
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("t2_inst_cnop", inst, 32'h1);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0);
            chk("t2_hold_valid", valid, 1'b1);
            chk("t2_hold_inst", inst, 32'h0093_0013);
            chk("t2_hold_pc", pc, 64'h2);
            chk("t2_hold_fready", fetch_ready, 1'b0);
        end
        cyc(1, 1, 0, 0);
        chk("t2_rel_inst", inst, 32'h0093_0013);
        cyc(1, 1, 0, 0);
        chk("t2_next_inst", inst, 32'h0000_1234);
        chk("t2_next_pc", pc, 64'h6);
        chk("t2_next_comp", compressed, 1'b1);
        chk("t2_faddr8", fetch_addr, 64'h8);
        cyc(1, 1, 0, 0);
        chk("t2_w2_inst", inst, 32'h1);
        chk("t2_w2_pc", pc, 64'h8);
        cyc(1, 1, 1, 64'h103);
        chk("t3_flush_valid", valid, 1'b0);
        chk("t3_flush_fready", fetch_ready, 1'b0);
        cyc(1, 1, 0, 0);
        chk("t3_post_valid", valid, 1'b0);
        chk("t3_post_faddr", fetch_addr, 64'h100);
        cyc(1, 1, 0, 0);
        chk("t3_cli_valid", valid, 1'b1);
        chk("t3_cli_inst", inst, 32'h0000_4505);
        chk("t3_cli_pc", pc, 64'h102);
        chk("t3_cli_comp", compressed, 1'b1);

        // Reset while the upper half of a straddle is outstanding.
        do_reset();
        mem[1] = 32'h00A0_0093;
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("t5_waiting", valid, 1'b0);
        chk("t5_wait_pc", pc, 64'h2);
        @(negedge clk);
        rst_n = 1'b0; fetch_valid = 1'b1; ready = 1'b1;
        #1;
        chk("t5_inrst_valid", valid, 1'b0);
        chk("t5_inrst_inst", inst, 32'h0);
        chk("t5_inrst_fready", fetch_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; fetch_valid = 1'b0;
        cyc(1, 1, 0, 0);
        chk("t5_faddr", fetch_addr, 64'h0);
        chk("t5_pc", pc, 64'h0);
        chk("t5_valid", valid, 1'b0);
        cyc(1, 1, 0, 0);
        chk("t5_first_inst", inst, 32'h1);
        chk("t5_first_pc", pc, 64'h0);

        // Random traffic against the memory-image model.
        do_reset();
        for (int i = 0; i < 128; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 1) == 0) w[1:0] = 2'(($urandom_range(0, 2)));
            else w[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 0) w[17:16] = 2'(($urandom_range(0, 2)));
            else w[17:16] = 2'b11;
            mem[i] = w;
        end
        exp_pc = 64'h0;
        prev_fl = 1'b0;
        consumes = 0;
        for (int n = 0; n < 3000; n++) begin
            fv  = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 49) == 0);
            fpc = 64'($urandom_range(0, 511));
            cyc(fv, rdy, fl, fpc);
            if (fl || prev_fl) chk("rnd_flush_valid", valid, 1'b0);
            if (fl) begin
                exp_pc = {fpc[63:1], 1'b0};
            end else if (valid && rdy) begin
                h = hw_at(exp_pc);
                chk("rnd_pc", pc, exp_pc);
                if (h[1:0] != 2'b11) begin
                    chk("rnd_comp", compressed, 1'b1);
                    chk("rnd_inst16", inst, {16'h0, h});
                    exp_pc = exp_pc + 64'd2;
                end else begin
                    chk("rnd_comp", compressed, 1'b0);
                    chk("rnd_inst32", inst, {hw_at(exp_pc + 64'd2), h});
                    exp_pc = exp_pc + 64'd4;
                end
                consumes++;
            end
            prev_fl = fl;
        end
        chk("rnd_progress", 64'(consumes > 500), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
